riscv_hazard_ctrl: RTL

//  Producer-side companion to the forwarding unit. Tracks in-flight destination registers for s3..s5.

---
 rtl/riscv_hazard_ctrl_pkg.sv | 28 ++
 rtl/riscv_hazard_ctrl_inst_dec_lite.sv | 60 ++++++
 rtl/riscv_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, NOP encoding, hazard FSM states and shadow-stage record.
// Also used by the forwarding unit.
package riscv_hazard_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // One in-flight producer: valid, destination register, is-a-load.
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } shadow_t;

endpackage

// File: rtl/riscv_hazard_ctrl_inst_dec_lite.sv
// riscv_inst_dec_lite: minimal register-usage decode of one 32-bit instruction.
// Shared by the hazard controller and the forwarding unit.
module riscv_inst_dec_lite
  import riscv_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_writes_rd,
  output logic        o_is_load,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd
);

  logic [6:0] w_op;
  logic       w_unused;

  assign w_op     = i_inst[6:0];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign o_rd     = i_inst[11:7];
  assign w_unused = ^{i_inst[31:25], i_inst[14:12]};

  always_comb begin
    o_uses_rs1  = 1'b0;
    o_uses_rs2  = 1'b0;
    o_writes_rd = 1'b0;
    o_is_load   = 1'b0;
    case (w_op)
      OP_R: begin
        o_uses_rs1  = 1'b1;
        o_uses_rs2  = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_I: begin
        o_uses_rs1  = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_LOAD: begin
        o_uses_rs1  = 1'b1;
        o_writes_rd = 1'b1;
        o_is_load   = 1'b1;
      end
      OP_S, OP_BR: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OP_JAL:  o_writes_rd = 1'b1;
      OP_JALR: begin
        o_uses_rs1  = 1'b1;
        o_writes_rd = 1'b1;
      end
      default: ;
    endcase
    // x0 is never a real destination, so it can never create a hazard.
    if (o_rd == 5'd0) o_writes_rd = 1'b0;
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the s1..s3 pipeline registers.
// Optional perf counters stall_cnt/flush_cnt are built only when HAZARD_PERF_CNT_EN is defined.
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_s2,
  input  logic             branch_taken_s3,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       dbg_state,
  output logic [20:0]      dbg_shadow
);

  localparam int         LD_REM_I = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
  localparam int         FL_REM_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam logic [1:0] LD_REM   = LD_REM_I[1:0];
  localparam logic [1:0] FL_REM   = FL_REM_I[1:0];

  hz_state_e  r_state, w_nxt_state;
  logic [1:0] r_rem, w_nxt_rem;
  shadow_t    r_s3, r_s4, r_s5, w_dec_s3;

  logic       w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;
  logic [4:0] w_rs1, w_rs2, w_rd;
  logic       w_lu_haz, w_stall, w_bubble, w_flush;

  riscv_inst_dec_lite u_dec (
    .i_inst      (inst_s2),
    .o_uses_rs1  (w_uses_rs1),
    .o_uses_rs2  (w_uses_rs2),
    .o_writes_rd (w_writes_rd),
    .o_is_load   (w_is_load),
    .o_rs1       (w_rs1),
    .o_rs2       (w_rs2),
    .o_rd        (w_rd)
  );

  assign w_dec_s3 = '{vld: w_writes_rd, rd: w_rd, ld: w_is_load};
  assign w_lu_haz = r_s3.vld & r_s3.ld &
                    ((w_uses_rs1 & (w_rs1 == r_s3.rd)) | (w_uses_rs2 & (w_rs2 == r_s3.rd)));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rem   = r_rem;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE, ST_STALL: begin
        // A taken branch wins over any load-use stall, including one in progress.
        if (branch_taken_s3) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_nxt_state = ST_FLUSH;
            w_nxt_rem   = FL_REM;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_rem   = 2'd0;
          end
        end else if (r_state == ST_STALL) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (r_rem == 2'd0) w_nxt_state = ST_IDLE;
          else               w_nxt_rem   = r_rem - 2'd1;
        end else if (w_lu_haz) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_nxt_state = ST_STALL;
            w_nxt_rem   = LD_REM;
          end
        end
      end
      ST_FLUSH: begin
        // Any branch seen here sits in an already-squashed slot.
        w_flush  = 1'b1;
        w_bubble = 1'b1;
        if (r_rem == 2'd0) w_nxt_state = ST_IDLE;
        else               w_nxt_rem   = r_rem - 2'd1;
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_rem   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= 2'd0;
      r_s3    <= '0;
      r_s4    <= '0;
      r_s5    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_rem   <= w_nxt_rem;
      r_s3    <= w_bubble ? '0 : w_dec_s3;
      r_s4    <= r_s3;
      r_s5    <= r_s4;
    end
  end

  // Gated by rst_n so a branch pulse during reset cannot leak out.
  assign stall_if   = rst_n & w_stall;
  assign stall_id   = rst_n & w_stall;
  assign bubble_ex  = rst_n & w_bubble;
  assign flush_id   = rst_n & w_flush;
  assign dbg_state  = r_state;
  assign dbg_shadow = {r_s3, r_s4, r_s5};

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule
